// File: rtl/prbs15_seq_checker.sv
// Receive-side checker: hunts for N back-to-back sync words, self-seeds a PRBS-15
// (x^15+x^14+1) LFSR from the stream, then counts bit errors and tracks lock.
module prbs15_seq_checker #(
  parameter logic [31:0] SEQ      = 32'hCCDDEEFF,
  parameter int          N        = 2,
  parameter int          ERR_W    = 16,
  parameter int          LOSS_THR = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             seq_found,
  output logic             seq_done,
  output logic             prbs_locked,
  output logic             prbs_err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    HUNT       = 2'd0,
    SEQ_CHECK  = 2'd1,
    PRBS_LOAD  = 2'd2,
    PRBS_CHECK = 2'd3
  } state_t;

  localparam logic [2:0] N_L      = 3'(N);
  localparam logic [3:0] LOSS_L   = 4'(LOSS_THR);
  localparam logic [4:0] LAST_IDX = 5'd31;

  state_t           st_q, st_d;
  logic [31:0]      window_q, window_d, window_shift;
  logic [4:0]       idx_q, idx_d;
  logic [2:0]       rep_q, rep_d, rep_inc;
  logic [3:0]       load_cnt_q, load_cnt_d;
  logic [14:0]      lfsr_q, lfsr_d, lfsr_shift;
  logic [3:0]       miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0] err_q, err_d;
  logic             seq_found_q, seq_found_d;
  logic             seq_done_q, seq_done_d;
  logic             locked_q, locked_d;
  logic             prbs_err_q, prbs_err_d;
  logic             exp_bit;
  logic             err_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= HUNT;
      window_q    <= '0;
      idx_q       <= '0;
      rep_q       <= '0;
      load_cnt_q  <= '0;
      lfsr_q      <= '0;
      miss_q      <= '0;
      err_q       <= '0;
      seq_found_q <= 1'b0;
      seq_done_q  <= 1'b0;
      locked_q    <= 1'b0;
      prbs_err_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      window_q    <= window_d;
      idx_q       <= idx_d;
      rep_q       <= rep_d;
      load_cnt_q  <= load_cnt_d;
      lfsr_q      <= lfsr_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      seq_found_q <= seq_found_d;
      seq_done_q  <= seq_done_d;
      locked_q    <= locked_d;
      prbs_err_q  <= prbs_err_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    window_d     = window_q;
    idx_d        = idx_q;
    rep_d        = rep_q;
    load_cnt_d   = load_cnt_q;
    lfsr_d       = lfsr_q;
    miss_d       = miss_q;
    err_d        = err_q;
    seq_found_d  = 1'b0;
    seq_done_d   = seq_done_q;
    locked_d     = locked_q;
    prbs_err_d   = 1'b0;
    err_hit      = 1'b0;
    window_shift = {window_q[30:0], bit_in};
    lfsr_shift   = {lfsr_q[13:0], bit_in};
    exp_bit      = lfsr_q[14] ^ lfsr_q[13];
    rep_inc      = rep_q + 3'd1;
    miss_inc     = miss_q + 4'd1;

    if (bit_valid) begin
      unique case (st_q)
        HUNT: begin
          window_d = window_shift;
          if (window_shift == SEQ) begin
            seq_found_d = 1'b1;
            rep_d       = 3'd1;
            idx_d       = '0;
            if (N == 1) begin
              seq_done_d = 1'b1;
              load_cnt_d = '0;
              lfsr_d     = '0;
              st_d       = PRBS_LOAD;
            end else begin
              st_d = SEQ_CHECK;
            end
          end
        end

        SEQ_CHECK: begin
          if (bit_in != SEQ[LAST_IDX - idx_q]) begin
            // The failing bit may itself start a new sync word, so keep it.
            st_d       = HUNT;
            rep_d      = '0;
            seq_done_d = 1'b0;
            idx_d      = '0;
            window_d   = {31'd0, bit_in};
          end else if (idx_q == LAST_IDX) begin
            seq_found_d = 1'b1;
            rep_d       = rep_inc;
            idx_d       = '0;
            if (rep_inc == N_L) begin
              seq_done_d = 1'b1;
              load_cnt_d = '0;
              lfsr_d     = '0;
              st_d       = PRBS_LOAD;
            end
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end

        PRBS_LOAD: begin
          lfsr_d = lfsr_shift;
          if (load_cnt_q == 4'd14) begin
            load_cnt_d = '0;
            if (lfsr_shift == '0) begin
              // An all-zero seed would lock the LFSR forever.
              st_d       = HUNT;
              seq_done_d = 1'b0;
              rep_d      = '0;
              window_d   = '0;
            end else begin
              st_d     = PRBS_CHECK;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end

        PRBS_CHECK: begin
          lfsr_d = {lfsr_q[13:0], exp_bit};
          if (bit_in != exp_bit) begin
            prbs_err_d = 1'b1;
            err_hit    = 1'b1;
            miss_d     = miss_inc;
            if (miss_inc == LOSS_L) begin
              st_d       = HUNT;
              locked_d   = 1'b0;
              seq_done_d = 1'b0;
              rep_d      = '0;
              miss_d     = '0;
              window_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end

        default: ;
      endcase
    end

    if (err_clr) begin
      err_d = '0;
    end else if (err_hit && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  assign seq_found   = seq_found_q;
  assign seq_done    = seq_done_q;
  assign prbs_locked = locked_q;
  assign prbs_err    = prbs_err_q;
  assign err_count   = err_q;
  assign state       = st_q;

endmodule

// File: doc/prbs15_seq_checker.md
Name: prbs15_seq_checker

Overview:
Receive-side stage that consumes the serial stream from the PRBS-15 pattern generator. The stream is a 32-bit sync word sent MSB-first N times back-to-back, followed by a continuous PRBS-15 (x^15+x^14+1) bit stream. The block hunts for the sync word and confirms N consecutive repetitions. It then self-seeds a local LFSR from the incoming PRBS bits and counts bit errors, reporting lock and loss-of-lock.

Parameters:
SEQ, 32'hCCDDEEFF, sync word expected MSB-first
N, 2, number of consecutive sync words required before PRBS checking (1..7)
ERR_W, 16, width of saturating error counter
LOSS_THR, 8, consecutive PRBS mismatches that drop lock (1..15)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
bit_in  in  1  serial data bit from generator
bit_valid  in  1  bit_in sampled only when high
err_clr  in  1  synchronous clear of err_count
seq_found  out  1  one-cycle pulse per complete matching sync word
seq_done  out  1  level; high once N consecutive sync words are confirmed, low in HUNT
prbs_locked  out  1  level; high in PRBS_CHECK
prbs_err  out  1  one-cycle pulse per mismatched PRBS bit
err_count  out  ERR_W  saturating count of PRBS bit errors
state  out  2  FSM state for debug: 0 HUNT, 1 SEQ_CHECK, 2 PRBS_LOAD, 3 PRBS_CHECK

Behaviour:
- Reset: state=HUNT; 32-bit window, word counter, bit counter and LFSR cleared. All outputs 0, including err_count.
- All outputs are registered. A bit sampled at edge k affects outputs visible after edge k (latency 1 clk).
- When bit_valid=0: no state, counter or window change; pulses deassert.
- HUNT:
  - window <= {window[30:0], bit_in}.
  - When the new window equals SEQ: pulse seq_found and set rep=1.
  - If N==1, go to PRBS_LOAD. Otherwise go to SEQ_CHECK with idx=0.
- SEQ_CHECK:
  - Compare bit_in with SEQ[31-idx].
  - On mismatch: return to HUNT, clear rep and seq_done; the window restarts from this bit.
  - When idx==31 and the bit matches: pulse seq_found and increment rep. If rep reaches N, set seq_done and go to PRBS_LOAD. Otherwise set idx=0.
- PRBS_LOAD:
  - Shift 15 bits into lfsr: lfsr <= {lfsr[13:0], bit_in}.
  - After the 15th bit: if lfsr is all zero, return to HUNT (lockup guard). Otherwise go to PRBS_CHECK and set prbs_locked.
- PRBS_CHECK:
  - Compute exp = lfsr[14]^lfsr[13]; lfsr <= {lfsr[13:0], exp}. The LFSR is free-running and is not reloaded from received data.
  - If bit_in != exp: pulse prbs_err, increment err_count, increment the consecutive-miss counter. A match clears the miss counter.
  - When the miss counter reaches LOSS_THR: go to HUNT; clear prbs_locked, seq_done and rep.
- err_count:
  - Saturates at all-ones with no wrap.
  - Retained across loss of lock; cleared only by rst or err_clr.
  - If err_clr and an error occur on the same edge, err_clr wins and the result is 0.
- seq_found and prbs_err never assert in the same cycle.
- Reset during any state returns immediately to the reset values above.

Test Plan:
- Generator model sends SEQ=CCDDEEFF ×2, then PRBS-15 from seed 0x7FFF, bit_valid=1. Required: seq_found pulses at bits 32 and 64; seq_done after bit 64; prbs_locked after bit 79; err_count stays 0 for 10000 bits.
- Same stream with PRBS bit 200 inverted. Required: exactly one prbs_err pulse, err_count=1, prbs_locked stays 1.
- Bit 40 of the second sync repetition is corrupted. Required: one seq_found pulse (at bit 32), state returns to HUNT, prbs_locked stays 0. A following clean SEQ×2 + PRBS stream then locks normally.
- After lock, force bit_in=0 for 8 bits on a stretch where PRBS expects mostly 1s, with 8 consecutive misses. Required: prbs_locked drops after the 8th miss, state=HUNT, err_count=8 is retained. Pulse err_clr with a simultaneous error: err_count=0.
- Toggle bit_valid randomly at 50% during the nominal stream. Required: results identical to the first scenario.
- Assert rst mid-PRBS_CHECK with err_count=5. Required: err_count=0, state=HUNT, all flags 0. Feed all-zero bits after a valid SEQ×2: the lockup guard returns the FSM to HUNT.
